// File: rtl/spi2apb3_host.sv
// SPI host that frames APB3 commands for the SPI-to-APB bridge: one 112-slot frame
// per command, idle frames in between, and a response pulse after each command frame.
module spi2apb3_host #(
    parameter logic [7:0] IDLE_OP = 8'h00
) (
    input  logic        SPICLK,
    input  logic        PRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [39:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [1:0]  rsp_op,
    output logic [31:0] rsp_rdata,
    output logic        MOSI,
    input  logic        MISO,
    output logic        busy
);

    localparam logic [0:0] IDLE_FRAME = 1'b0;
    localparam logic [0:0] CMD_FRAME  = 1'b1;
    localparam logic [6:0] LAST_SLOT  = 7'd111;
    localparam logic [6:0] DOUT_SLOT  = 7'd80;

    // Handshake: a command is taken on any rising edge with cmd_valid && cmd_ready.
    // cmd_ready is simply "holding register empty"; cmd_valid may drop freely.

    logic [6:0]   fcnt_q, fcnt_d;
    logic [0:0]   state_q, state_d;
    logic         pending_q, pending_d;
    logic [1:0]   hold_op_q, hold_op_d;
    logic [39:0]  hold_addr_q, hold_addr_d;
    logic [31:0]  hold_wdata_q, hold_wdata_d;
    logic [1:0]   cur_op_q, cur_op_d;
    logic [110:0] sreg_q, sreg_d;
    logic         mosi_q, mosi_d;
    logic [31:0]  rx_q, rx_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [1:0]   rsp_op_q, rsp_op_d;
    logic [31:0]  rsp_rdata_q, rsp_rdata_d;

    logic         wrap, accept, load_cmd;
    logic [1:0]   sel_op;
    logic [39:0]  sel_addr;
    logic [31:0]  sel_wdata;
    logic [111:0] new_frame;

    function automatic logic [7:0] op_byte(input logic [1:0] op);
        case (op)
            2'b00:   op_byte = 8'h20;
            2'b01:   op_byte = 8'hA0;
            2'b10:   op_byte = 8'h40;
            default: op_byte = 8'hC0;
        endcase
    endfunction

    always_comb begin
        wrap      = (fcnt_q == LAST_SLOT);
        accept    = cmd_valid & ~pending_q;
        // A pending command wins; otherwise an edge-111 acceptance bypasses the holding register.
        load_cmd  = pending_q | accept;
        sel_op    = pending_q ? hold_op_q    : cmd_op;
        sel_addr  = pending_q ? hold_addr_q  : cmd_addr;
        sel_wdata = pending_q ? hold_wdata_q : cmd_wdata;
        new_frame = load_cmd ? {op_byte(sel_op), sel_addr, (sel_op[0] ? sel_wdata : 32'h0), 32'h0}
                             : {IDLE_OP, 104'h0};

        fcnt_d       = wrap ? 7'd0 : fcnt_q + 7'd1;
        state_d      = state_q;
        pending_d    = pending_q;
        hold_op_d    = hold_op_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        cur_op_d     = cur_op_q;
        rx_d         = rx_q;
        rsp_valid_d  = 1'b0;
        rsp_op_d     = rsp_op_q;
        rsp_rdata_d  = rsp_rdata_q;
        mosi_d       = sreg_q[110];
        sreg_d       = {sreg_q[109:0], 1'b0};

        if (accept) begin
            pending_d    = 1'b1;
            hold_op_d    = cmd_op;
            hold_addr_d  = cmd_addr;
            hold_wdata_d = cmd_wdata;
        end
        if (state_q == CMD_FRAME && fcnt_q >= DOUT_SLOT) begin
            rx_d = {rx_q[30:0], MISO};
        end
        if (wrap) begin
            pending_d   = 1'b0;
            state_d     = load_cmd ? CMD_FRAME : IDLE_FRAME;
            cur_op_d    = load_cmd ? sel_op : 2'b00;
            mosi_d      = new_frame[111];
            sreg_d      = new_frame[110:0];
            if (state_q == CMD_FRAME) begin
                rsp_valid_d = 1'b1;
                rsp_op_d    = cur_op_q;
                rsp_rdata_d = cur_op_q[0] ? 32'h0 : rx_d;
            end
        end
    end

    always_ff @(posedge SPICLK or negedge PRESETn) begin
        if (!PRESETn) begin
            fcnt_q       <= 7'd0;
            state_q      <= IDLE_FRAME;
            pending_q    <= 1'b0;
            hold_op_q    <= 2'b00;
            hold_addr_q  <= 40'h0;
            hold_wdata_q <= 32'h0;
            cur_op_q     <= 2'b00;
            sreg_q       <= {IDLE_OP[6:0], 104'h0};
            mosi_q       <= 1'b0;
            rx_q         <= 32'h0;
            rsp_valid_q  <= 1'b0;
            rsp_op_q     <= 2'b00;
            rsp_rdata_q  <= 32'h0;
        end else begin
            fcnt_q       <= fcnt_d;
            state_q      <= state_d;
            pending_q    <= pending_d;
            hold_op_q    <= hold_op_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            cur_op_q     <= cur_op_d;
            sreg_q       <= sreg_d;
            mosi_q       <= mosi_d;
            rx_q         <= rx_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_op_q     <= rsp_op_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign cmd_ready = ~pending_q;
    assign busy      = (state_q == CMD_FRAME);
    assign MOSI      = mosi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_op    = rsp_op_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi2apb3_host.sv
// Directed bench for spi2apb3_host with a small bit-level model of the SPI-to-APB bridge.
module tb_spi2apb3_host;

  logic        SPICLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [39:0] cmd_addr = 40'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic        rsp_valid;
  logic [1:0]  rsp_op;
  logic [31:0] rsp_rdata;
  logic        MOSI;
  logic        MISO;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int rsp_count = 0;
  logic [33:0] exp_q[$];

  spi2apb3_host dut (
    .SPICLK(SPICLK), .PRESETn(PRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_op(rsp_op), .rsp_rdata(rsp_rdata), .MOSI(MOSI), .MISO(MISO), .busy(busy)
  );

  // clock / reset
  always #5 SPICLK = ~SPICLK;

  // bridge model: slot counter, frame capture, read data returned on MISO in slots 80..111
  logic [6:0]   bcnt;
  logic [110:0] bsh;
  logic [31:0]  tx_q, cfg_q, last_din;
  logic [7:0]   last_cmd;
  logic [39:0]  last_addr;
  int           frame_num, last_frame, prev_frame;
  logic [79:0]  f80;
  assign f80  = {bsh[78:0], MOSI};
  assign MISO = tx_q[31];

  function automatic logic [31:0] mem_rd(input logic [39:0] a);
    mem_rd = (a == 40'h00_2000_0000) ? 32'h12345678 : (32'hCAFE0000 | {16'h0, a[15:0]});
  endfunction

  always @(posedge SPICLK or negedge PRESETn) begin
    if (!PRESETn) begin
      bcnt <= 7'd0; bsh <= '0; tx_q <= 32'h0; cfg_q <= 32'h0; frame_num <= 0;
    end else begin
      bcnt <= (bcnt == 7'd111) ? 7'd0 : bcnt + 7'd1;
      bsh  <= {bsh[109:0], MOSI};
      if (bcnt == 7'd111) frame_num <= frame_num + 1;
      if (bcnt == 7'd79) begin
        tx_q <= 32'h0;
        if (f80[79:72] != 8'h00) begin
          prev_frame <= last_frame;
          last_frame <= frame_num;
          last_cmd   <= f80[79:72];
          last_addr  <= f80[71:32];
          last_din   <= f80[31:0];
        end
        case (f80[79:72])
          8'h20:   tx_q  <= mem_rd(f80[71:32]);
          8'h40:   tx_q  <= cfg_q;
          8'hC0:   cfg_q <= f80[31:0];
          default: ;
        endcase
      end else if (bcnt >= 7'd80) begin
        tx_q <= {tx_q[30:0], 1'b0};
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every rsp_valid pulse is matched against the expected queue
  logic prev_rv = 1'b0;
  always @(negedge SPICLK) begin
    if (PRESETn && rsp_valid) begin
      rsp_count++;
      check("rsp_one_cycle", 64'(prev_rv), 64'(0));
      check("rsp_slot", 64'(bcnt), 64'(0));
      if (exp_q.size() == 0) check("rsp_unexpected", 64'(1), 64'(0));
      else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("rsp_op", 64'(rsp_op), 64'(e[33:32]));
        check("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
      end
    end
    prev_rv = rsp_valid;
  end

  // driver tasks
  task automatic wait_slot(input logic [6:0] k);
    int n = 0;
    do begin
      @(negedge SPICLK);
      n++;
    end while (bcnt != k && n < 300);
    if (bcnt != k) check("wait_slot_timeout", 64'(bcnt), 64'(k));
  endtask

  task automatic issue(input logic [1:0] op, input logic [39:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, output logic [6:0] acc_slot);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 400) begin
      @(negedge SPICLK);
      n++;
    end
    acc_slot = bcnt;
    if (!cmd_ready) check("issue_timeout", 64'(cmd_ready), 64'(1));
    else begin
      exp_q.push_back({op, exp_rd});
      @(posedge SPICLK);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge SPICLK);
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'(0));
    repeat (3) @(negedge SPICLK);
  endtask

  logic [6:0] acc;
  int saved_count;

  initial begin
    // reset state
    repeat (3) @(negedge SPICLK);
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_op", 64'(rsp_op), 64'(0));
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("rst_mosi", 64'(MOSI), 64'(0));
    check("rst_fcnt", 64'(dut.fcnt_q), 64'(0));
    PRESETn = 1'b1;

    wait_slot(7'd5);
    check("idle_busy", 64'(busy), 64'(0));

    // write accepted in slot 20, carried by the next frame
    wait_slot(7'd20);
    issue(2'b01, 40'h00_4000_0010, 32'hDEADBEEF, 32'h0, acc);
    wait_slot(7'd0);
    check("wr_busy", 64'(busy), 64'(1));
    check("wr_mosi_msb", 64'(MOSI), 64'(1));
    wait_slot(7'd90);
    check("wr_cmd", 64'(last_cmd), 64'(8'hA0));
    check("wr_addr", 64'(last_addr), 64'(40'h00_4000_0010));
    check("wr_din", 64'(last_din), 64'(32'hDEADBEEF));
    drain();

    // read through the bridge model
    issue(2'b00, 40'h00_2000_0000, 32'hFFFF_FFFF, 32'h12345678, acc);
    drain();
    check("rd_cmd", 64'(last_cmd), 64'(8'h20));
    check("rd_din_zero", 64'(last_din), 64'(0));

    // back-to-back: second command waits for the wrap, frames are consecutive
    wait_slot(7'd50);
    issue(2'b01, 40'h00_0000_0100, 32'h11112222, 32'h0, acc);
    @(negedge SPICLK);
    check("b2b_ready_low", 64'(cmd_ready), 64'(0));
    issue(2'b11, 40'h0, 32'hA5A5_0001, 32'h0, acc);
    check("b2b_accept_slot", 64'(acc), 64'(0));
    drain();
    check("b2b_consecutive", 64'(last_frame - prev_frame), 64'(1));
    check("cfg_wr_cmd", 64'(last_cmd), 64'(8'hC0));
    check("cfg_data", 64'(cfg_q), 64'(32'hA5A5_0001));

    // cfg read returns the value just written
    issue(2'b10, 40'h0, 32'h0, 32'hA5A5_0001, acc);
    drain();
    check("cfg_rd_cmd", 64'(last_cmd), 64'(8'h40));

    // bypass: accepted on the edge ending slot 111 with the holding register empty
    wait_slot(7'd111);
    check("byp_ready", 64'(cmd_ready), 64'(1));
    issue(2'b01, 40'h12_3456_789A, 32'h0BAD_F00D, 32'h0, acc);
    @(negedge SPICLK);
    check("byp_slot", 64'(bcnt), 64'(0));
    check("byp_mosi", 64'(MOSI), 64'(1));
    check("byp_busy", 64'(busy), 64'(1));
    drain();
    check("byp_addr", 64'(last_addr), 64'(40'h12_3456_789A));
    check("byp_din", 64'(last_din), 64'(32'h0BAD_F00D));

    // reset in the middle of a read frame: no response, realigned afterwards
    wait_slot(7'd100);
    issue(2'b00, 40'h00_2000_0000, 32'h0, 32'h12345678, acc);
    wait_slot(7'd60);
    check("rst_mid_busy", 64'(busy), 64'(1));
    exp_q.delete();
    saved_count = rsp_count;
    PRESETn = 1'b0;
    #1;
    check("rst_mid_mosi", 64'(MOSI), 64'(0));
    check("rst_mid_fcnt", 64'(dut.fcnt_q), 64'(0));
    check("rst_mid_busy_low", 64'(busy), 64'(0));
    check("rst_mid_ready", 64'(cmd_ready), 64'(1));
    @(negedge SPICLK);
    PRESETn = 1'b1;
    repeat (250) @(negedge SPICLK);
    check("rst_mid_no_rsp", 64'(rsp_count), 64'(saved_count));
    issue(2'b00, 40'h00_2000_0000, 32'h0, 32'h12345678, acc);
    drain();
    check("rsp_total", 64'(rsp_count), 64'(7));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi2apb3_host.md
SPI2APB3_HOST -- requirements
Module: spi2apb3_host

Interface
REQ-001 Parameter IDLE_OP, default 8'h00, is the command byte sent in frames that carry no host command; it SHALL be a value the bridge ignores.
REQ-002 SPICLK  input  1  serial clock; all sequential logic SHALL be clocked on its rising edge.
REQ-003 PRESETn  input  1  reset; asynchronous, active-low; it is the same net that resets the SPI-to-APB bridge.
REQ-004 cmd_valid  input  1  host command request.
REQ-005 cmd_ready  output  1  holding register free; a command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1.
REQ-006 cmd_op  input  2  operation: 00 read (8'h20), 01 write (8'hA0), 10 cfg read (8'h40), 11 cfg write (8'hC0).
REQ-007 cmd_addr  input  40  transfer address.
REQ-008 cmd_wdata  input  32  write / cfg-write data.
REQ-009 rsp_valid  output  1  one-cycle pulse when a command frame completes.
REQ-010 rsp_op  output  2  cmd_op of the completed frame.
REQ-011 rsp_rdata  output  32  data captured from MISO for read ops; 0 for write ops.
REQ-012 MOSI  output  1  serial data to the bridge SPIDI.
REQ-013 MISO  input  1  serial data from the bridge SPIDO.
REQ-014 busy  output  1  high while the current frame is a command frame.

Function
REQ-015 A 7-bit slot counter fcnt SHALL count 0..111 and wrap to 0; it free-runs from reset release so that frames stay aligned with the bridge's bit counter.
REQ-016 Each frame SHALL be 112 slots, MSB first: slots 0-7 command byte, 8-47 address[39:0], 48-79 data-in[31:0], 80-111 data-out (MOSI=0).
REQ-017 MOSI SHALL be a registered output; during slot k it SHALL carry frame bit k, updated on the rising edge that starts slot k.
REQ-018 The frame loaded at the 111->0 wrap SHALL be the command frame if a command is pending in the holding register; otherwise it SHALL be an idle frame (IDLE_OP, all-zero address and data).
REQ-019 Bypass: a command accepted on the edge ending slot 111 with no command pending SHALL be loaded directly into the new frame.
REQ-020 For read and cfg-read ops, the data-in slots SHALL be driven 0.
REQ-021 The holding register SHALL be one entry deep: cmd_ready = ~pending; pending is set on acceptance and cleared when it is loaded into a frame.
REQ-022 State machine states: IDLE_FRAME and CMD_FRAME; the state SHALL be re-evaluated only at the 111->0 wrap; busy=1 in CMD_FRAME.
REQ-023 For read ops in CMD_FRAME, MISO SHALL be shifted in MSB first on the rising edges ending slots 80..111.
REQ-024 rsp_valid SHALL pulse for exactly one cycle on the edge after the last data-out bit is captured (the first cycle of slot 0 of the next frame), together with rsp_op and rsp_rdata.
REQ-025 No response SHALL be generated for idle frames.
REQ-026 The APB read must complete within slots 48-79; this is a system constraint, and the host does not check it.

Reset
REQ-027 While PRESETn=0: fcnt=0, state=IDLE_FRAME, pending=0, MOSI=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_op=0, rsp_rdata=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame and drop any pending command with no response; after release, the first frame SHALL be idle unless the bypass in REQ-019 applies at slot 111.

Verification
REQ-029 Write op=01, addr=40'h00_4000_0010, wdata=32'hDEADBEEF accepted in slot 20 -> the next frame shows MOSI bits A0/0040000010/DEADBEEF; rsp_valid pulses at the following wrap with rsp_rdata=0.
REQ-030 Read op=00, addr=40'h0_2000_0000, with a bridge model returning 32'h12345678 -> rsp_rdata=32'h12345678 and exactly one rsp_valid pulse.
REQ-031 Back-to-back commands: second cmd_valid held during the first command frame -> cmd_ready=0 until the wrap, and the two frames are sent consecutively with no idle frame between them.
REQ-032 Command accepted on the edge ending slot 111 with the holding register empty -> slot 0 of the next frame carries the command MSB (bypass), busy=1.
REQ-033 cfg write 32'hA5A5_0001, then cfg read -> bridge SPI_CFGDATA=32'hA5A50001 and rsp_rdata=32'hA5A50001.
REQ-034 PRESETn pulsed low at slot 60 of a read frame -> no rsp_valid; MOSI=0 and fcnt=0 after release; frame alignment with the bridge is restored.
